// File: rtl/fifo_read.sv
// Read-side controller for the FIFO test bench: waits for almost_full, settles,
// drains until almost_empty and checks the data against an incrementing byte sequence.
module fifo_read #(
  parameter int DATA_W       = 8,
  parameter int DELAY_CYCLES = 10,
  parameter int CNT_W        = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              almost_full,
  input  logic              almost_empty,
  input  logic              empty,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  output logic [CNT_W-1:0]  burst_cnt,
  output logic              burst_done,
  output logic              err_flag,
  output logic [7:0]        err_cnt
);

  localparam int DLY_W = $clog2(DELAY_CYCLES + 2);

  typedef enum logic [1:0] {IDLE, DELAY, READ} state_t;

  state_t             state, state_nxt;
  logic [DLY_W-1:0]   dly_cnt, dly_cnt_nxt;
  logic               rd_req, rd_req_nxt;
  logic               burst_done_nxt;
  logic               burst_start;
  logic               af_d0, af_d1, af_rise;
  logic               cap;
  logic [DATA_W-1:0]  exp_val;

  assign af_rise    = af_d0 & ~af_d1;
  // Never strobe an empty FIFO; a request during empty is simply a stall.
  assign fifo_rd_en = rd_req & ~empty;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      dly_cnt    <= '0;
      rd_req     <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      dly_cnt    <= dly_cnt_nxt;
      rd_req     <= rd_req_nxt;
      burst_done <= burst_done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    dly_cnt_nxt    = dly_cnt;
    rd_req_nxt     = rd_req;
    burst_done_nxt = 1'b0;
    burst_start    = 1'b0;
    case (state)
      IDLE: begin
        if (af_rise) begin
          state_nxt   = DELAY;
          dly_cnt_nxt = '0;
          burst_start = 1'b1;
        end
      end
      DELAY: begin
        if (dly_cnt == DLY_W'(DELAY_CYCLES)) begin
          dly_cnt_nxt = '0;
          rd_req_nxt  = 1'b1;
          state_nxt   = READ;
        end else begin
          dly_cnt_nxt = dly_cnt + 1'b1;
        end
      end
      READ: begin
        if (almost_empty) begin
          rd_req_nxt     = 1'b0;
          burst_done_nxt = 1'b1;
          state_nxt      = IDLE;
        end
      end
      default: begin
        state_nxt   = IDLE;
        rd_req_nxt  = 1'b0;
        dly_cnt_nxt = '0;
      end
    endcase
  end

  // Capture/check pipeline: cap marks the cycle the strobed word is on fifo_rdata.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      af_d0         <= 1'b0;
      af_d1         <= 1'b0;
      cap           <= 1'b0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
      burst_cnt     <= '0;
      exp_val       <= '0;
      err_flag      <= 1'b0;
      err_cnt       <= '0;
    end else begin
      af_d0         <= almost_full;
      af_d1         <= af_d0;
      cap           <= fifo_rd_en;
      rd_data_valid <= cap;
      if (cap) rd_data <= fifo_rdata;
      if (burst_start) begin
        burst_cnt <= '0;
        exp_val   <= '0;
      end else if (cap) begin
        burst_cnt <= burst_cnt + 1'b1;
        // On a match this is exp+1; on a mismatch it resynchronises to the data.
        exp_val   <= fifo_rdata + 1'b1;
      end
      if (cap && (fifo_rdata != exp_val)) begin
        err_flag <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_read.sv
// Bench for fifo_read: behavioural FIFO plus table-driven and random bursts.
module tb_fifo_read;
  localparam int MSZ = 8192;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        almost_full = 1'b0;
  logic        almost_empty, empty;
  logic [7:0]  fifo_rdata = 8'h00;
  logic        fifo_rd_en;
  logic [7:0]  rd_data;
  logic        rd_data_valid;
  logic [15:0] burst_cnt;
  logic        burst_done;
  logic        err_flag;
  logic [7:0]  err_cnt;

  logic [7:0]  mem [MSZ];
  int          rd_ptr = 0;
  int          wr_cnt = 0;
  int          base = 0;
  logic        stall = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int          model_err = 0;

  typedef struct {
    int n; int cidx; int cval; int stall_at; int pulse_at; int pops; int nerr;
  } vec_t;
  vec_t tbl [7];

  fifo_read dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .almost_full(almost_full),
    .almost_empty(almost_empty), .empty(empty), .fifo_rdata(fifo_rdata),
    .fifo_rd_en(fifo_rd_en), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .burst_cnt(burst_cnt), .burst_done(burst_done), .err_flag(err_flag),
    .err_cnt(err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // Standard-mode FIFO: data appears the cycle after the strobe.
  assign empty        = (rd_ptr == wr_cnt) || stall;
  assign almost_empty = (wr_cnt - rd_ptr) <= 2;
  always @(posedge sys_clk) begin
    if (fifo_rd_en) begin
      fifo_rdata <= mem[rd_ptr % MSZ];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic logic [7:0] word(input int i, input int cidx, input int cval);
    logic [7:0] w;
    w = (i == cidx) ? 8'(cval) : 8'(i);
    return w;
  endfunction

  task automatic run_burst(input vec_t v);
    int cyc, bd, post, vcnt, stall_left;
    bit stalled, pulsed;
    base = rd_ptr;
    for (int i = 0; i < v.n; i++) mem[(base + i) % MSZ] = word(i, v.cidx, v.cval);
    wr_cnt = base + v.n;
    almost_full = 1'b1;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(negedge sys_clk);
      if (fifo_rd_en) break;
    end
    // 1 edge into af_d0, 1 to leave IDLE, 11 in DELAY.
    check("first_strobe_cycle", cyc, 13);
    almost_full = 1'b0;
    bd = 0; post = 0; vcnt = 0; stall_left = 0; stalled = 0; pulsed = 0;
    for (int c = 0; c < 2 * v.n + 100; c++) begin
      @(negedge sys_clk);
      if (rd_data_valid) begin
        check("rd_data", rd_data, mem[(base + vcnt) % MSZ]);
        vcnt++;
      end
      if (stall) begin
        check("stall_rd_en", fifo_rd_en, 0);
        stall_left--;
        if (stall_left == 0) stall = 1'b0;
      end else if (!stalled && v.stall_at > 0 && rd_ptr - base == v.stall_at) begin
        stall = 1'b1; stall_left = 3; stalled = 1;
      end
      if (pulsed) almost_full = 1'b0;
      else if (v.pulse_at > 0 && rd_ptr - base == v.pulse_at) begin
        almost_full = 1'b1; pulsed = 1;
      end
      if (burst_done) bd++;
      if (bd > 0) post++;
      if (post == 4) break;
    end
    stall = 1'b0;
    almost_full = 1'b0;
    model_err = (model_err + v.nerr > 255) ? 255 : model_err + v.nerr;
    check("burst_done_pulses", bd, 1);
    check("words_popped", rd_ptr - base, v.pops);
    check("valid_count", vcnt, v.pops);
    check("burst_cnt", burst_cnt, v.pops);
    check("err_cnt", err_cnt, model_err);
    check("err_flag", err_flag, model_err > 0);
    check("idle_rd_en", fifo_rd_en, 0);
    repeat (3) @(negedge sys_clk);
  endtask

  initial begin
    int n;
    vec_t v;
    logic [7:0] e, w;
    // n, corrupt idx, corrupt val, stall_at, af pulse_at, expected pops, expected new errors
    tbl[0] = '{251, -1, 0,    -1, -1, 250, 0};  // 0..250, stops at almost_empty
    tbl[1] = '{11,   3, 8'h55, -1, -1, 10,  2};  // 0x55 and the following 4 both mismatch
    tbl[2] = '{262, -1, 0,    -1, -1, 261, 0};  // 255 -> 0 wrap inside the burst
    tbl[3] = '{20,  -1, 0,     5, -1, 19,  0};  // 3-cycle empty stall
    tbl[4] = '{30,  -1, 0,    -1,  8, 29,  0};  // almost_full re-pulse during READ
    tbl[5] = '{1,   -1, 0,    -1, -1, 1,   0};  // almost_empty already set on entry
    tbl[6] = '{2,   -1, 0,    -1, -1, 1,   0};

    repeat (3) @(negedge sys_clk);
    check("reset_rd_en", fifo_rd_en, 0);
    check("reset_outputs",
          int'(|{rd_data, rd_data_valid, burst_cnt, burst_done, err_flag, err_cnt}), 0);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);

    foreach (tbl[k]) run_burst(tbl[k]);

    // Reset in the middle of a read burst.
    base = rd_ptr;
    for (int i = 0; i < 50; i++) mem[(base + i) % MSZ] = 8'(i);
    wr_cnt = base + 50;
    almost_full = 1'b1;
    for (int c = 0; c < 40 && !fifo_rd_en; c++) @(negedge sys_clk);
    almost_full = 1'b0;
    repeat (5) @(negedge sys_clk);
    check("pre_reset_rd_en", fifo_rd_en, 1);
    sys_rst = 1'b1;
    #1;
    check("reset_rd_en_drop", fifo_rd_en, 0);
    check("reset_outputs_mid",
          int'(|{rd_data, rd_data_valid, burst_cnt, burst_done, err_flag, err_cnt}), 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    n = 0;
    repeat (30) begin
      @(negedge sys_clk);
      if (fifo_rd_en) n++;
    end
    check("no_read_after_reset", n, 0);
    wr_cnt = rd_ptr;
    model_err = 0;

    // Random bursts against the sequence rule.
    for (int r = 0; r < 8; r++) begin
      v.n        = $urandom_range(1, 300);
      v.pops     = (v.n >= 2) ? v.n - 1 : 1;
      v.cidx     = ($urandom % 2 == 1) ? int'($urandom_range(0, v.pops - 1)) : -1;
      v.cval     = $urandom_range(0, 255);
      v.stall_at = (v.n >= 6 && $urandom % 2 == 1) ? int'($urandom_range(1, v.n - 3)) : -1;
      v.pulse_at = -1;
      v.nerr     = 0;
      e = 8'h00;
      for (int i = 0; i < v.pops; i++) begin
        w = word(i, v.cidx, v.cval);
        if (w != e) v.nerr++;
        e = w + 8'h01;
      end
      run_burst(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
